// File: rtl/decode_imm_arith_pipe.sv
// OP-IMM / OP-IMM-32 decoder between fetch and execute issue.
// Valid/ready in and out, one-entry skid buffer, flush, saturating illegal counter.

package decode_imm_arith_pkg;
  typedef enum logic [3:0] {
    iak_invalid = 4'd0,
    iak_addi,
    iak_slti,
    iak_sltiu,
    iak_xori,
    iak_ori,
    iak_andi,
    iak_slli,
    iak_srli,
    iak_srai,
    iak_addiw,
    iak_slliw,
    iak_srliw,
    iak_sraiw
  } imm_arith_kind_t;
endpackage

module decode_imm_arith_pipe
  import decode_imm_arith_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output imm_arith_kind_t       out_kind,
  output logic                  out_illegal,
  output logic [4:0]            out_rd,
  output logic [4:0]            out_rs1,
  output logic [XLEN-1:0]       out_imm,
  output logic [5:0]            out_shamt,
  output logic [CNT_W-1:0]      illegal_count
);

  typedef struct packed {
    imm_arith_kind_t kind;
    logic            illegal;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [XLEN-1:0] imm;
    logic [5:0]      shamt;
  } dec_t;

  localparam dec_t DecReset = '{kind: iak_invalid, illegal: 1'b0, rd: '0, rs1: '0,
                                imm: '0, shamt: '0};

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t       d;
    logic [6:0] f7;
    logic [2:0] f3;
    f7      = instr[31:25];
    f3      = instr[14:12];
    d.kind  = iak_invalid;
    d.rd    = instr[11:7];
    d.rs1   = instr[19:15];
    d.imm   = {{(XLEN-12){instr[31]}}, instr[31:20]};
    d.shamt = '0;
    case (instr[6:0])
      7'b0010011: begin
        case (f3)
          3'b000: d.kind = iak_addi;
          3'b010: d.kind = iak_slti;
          3'b011: d.kind = iak_sltiu;
          3'b100: d.kind = iak_xori;
          3'b110: d.kind = iak_ori;
          3'b111: d.kind = iak_andi;
          3'b001: begin
            if ((XLEN == 32) ? (f7 == 7'b0000000) : (instr[31:26] == 6'b000000))
              d.kind = iak_slli;
          end
          3'b101: begin
            if ((XLEN == 32) ? (f7 == 7'b0000000) : (instr[31:26] == 6'b000000))
              d.kind = iak_srli;
            else if ((XLEN == 32) ? (f7 == 7'b0100000) : (instr[31:26] == 6'b010000))
              d.kind = iak_srai;
          end
          default: d.kind = iak_invalid;
        endcase
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          case (f3)
            3'b000: d.kind = iak_addiw;
            3'b001: if (f7 == 7'b0000000) d.kind = iak_slliw;
            3'b101: begin
              if (f7 == 7'b0000000)      d.kind = iak_srliw;
              else if (f7 == 7'b0100000) d.kind = iak_sraiw;
            end
            default: d.kind = iak_invalid;
          endcase
        end
      end
      default: d.kind = iak_invalid;
    endcase
    // Only shift kinds carry a shift amount; the word forms are always 5 bits.
    case (d.kind)
      iak_slli, iak_srli, iak_srai:
        d.shamt = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};
      iak_slliw, iak_srliw, iak_sraiw:
        d.shamt = {1'b0, instr[24:20]};
      default: d.shamt = '0;
    endcase
    d.illegal = (d.kind == iak_invalid);
    return d;
  endfunction

  dec_t             main_q, main_d;
  logic             main_valid_q, main_valid_d;
  logic [31:0]      skid_instr_q, skid_instr_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  dec_t in_dec, skid_dec;
  logic in_fire, out_fire, main_free;

  // The skid holds the raw word and is decoded when it moves into main.
  assign in_dec    = decode(in_instr);
  assign skid_dec  = decode(skid_instr_q);
  assign in_ready  = rst & ~skid_valid_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_valid_q & out_ready;
  assign main_free = ~main_valid_q | out_ready;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_instr_d = skid_instr_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;
    if (out_fire && main_q.illegal && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
    if (flush) begin
      main_d       = DecReset;
      main_valid_d = 1'b0;
      skid_instr_d = '0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        main_d       = skid_dec;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_d       = in_dec;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_instr_d = in_instr;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q       <= DecReset;
      main_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid     = main_valid_q;
  assign out_kind      = main_q.kind;
  assign out_illegal   = main_q.illegal;
  assign out_rd        = main_q.rd;
  assign out_rs1       = main_q.rs1;
  assign out_imm       = main_q.imm;
  assign out_shamt     = main_q.shamt;
  assign illegal_count = cnt_q;

endmodule

// File: tb/tb_decode_imm_arith_pipe.sv
// Directed bench: XLEN=32 (a), XLEN=64 (b) and XLEN=32/CNT_W=2 (c) share stimulus.
module tb_decode_imm_arith_pipe;
  import decode_imm_arith_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] in_instr = '0;

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [21:0] got, exp;

  logic rdy_a, v_a, il_a, rdy_b, v_b, il_b, rdy_c, v_c, il_c;
  imm_arith_kind_t k_a, k_b, k_c;
  logic [4:0] rd_a, rs_a, rd_b, rs_b, rd_c, rs_c;
  logic [31:0] imm_a, imm_c;
  logic [63:0] imm_b;
  logic [5:0] sh_a, sh_b, sh_c;
  logic [15:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  decode_imm_arith_pipe #(.XLEN(32), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
    .in_instr(in_instr), .out_valid(v_a), .out_ready(out_ready), .out_kind(k_a),
    .out_illegal(il_a), .out_rd(rd_a), .out_rs1(rs_a), .out_imm(imm_a),
    .out_shamt(sh_a), .illegal_count(cnt_a));

  decode_imm_arith_pipe #(.XLEN(64), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
    .in_instr(in_instr), .out_valid(v_b), .out_ready(out_ready), .out_kind(k_b),
    .out_illegal(il_b), .out_rd(rd_b), .out_rs1(rs_b), .out_imm(imm_b),
    .out_shamt(sh_b), .illegal_count(cnt_b));

  decode_imm_arith_pipe #(.XLEN(32), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_c),
    .in_instr(in_instr), .out_valid(v_c), .out_ready(out_ready), .out_kind(k_c),
    .out_illegal(il_c), .out_rd(rd_c), .out_rs1(rs_c), .out_imm(imm_c),
    .out_shamt(sh_c), .illegal_count(cnt_c));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    got = {v_a, k_a, il_a, rd_a, rs_a, sh_a}; exp = '0;
    total++; if (got !== exp) begin bad++; $display("FAIL reset_fields_a got=%h exp=%h", got, exp); end
    got = {v_b, k_b, il_b, rd_b, rs_b, sh_b};
    total++; if (got !== exp) begin bad++; $display("FAIL reset_fields_b got=%h exp=%h", got, exp); end
    got = {v_c, k_c, il_c, rd_c, rs_c, sh_c};
    total++; if (got !== exp) begin bad++; $display("FAIL reset_fields_c got=%h exp=%h", got, exp); end
    total++;
    if ({imm_a, imm_b, imm_c, cnt_a, cnt_b, cnt_c, rdy_a, rdy_b, rdy_c} !== '0) begin
      bad++;
      $display("FAIL reset_misc imm_a=%h imm_b=%h imm_c=%h cnt=%h/%h/%h rdy=%b%b%b exp=all zero",
               imm_a, imm_b, imm_c, cnt_a, cnt_b, cnt_c, rdy_a, rdy_b, rdy_c);
    end
    step();
    rst = 1'b1;
    #1;
    total++; if (rdy_a !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b exp=1", rdy_a); end
  endtask

  task automatic test_decode();
    apply_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    in_instr = 32'hFFF10093;
    step();
    in_instr = 32'h40725193;
    got = {v_a, k_a, il_a, rd_a, rs_a, sh_a}; exp = {1'b1, iak_addi, 1'b0, 5'd1, 5'd2, 6'd0};
    total++; if (got !== exp) begin bad++; $display("FAIL addi_a got=%h exp=%h", got, exp); end
    total++; if (imm_a !== 32'hFFFFFFFF) begin bad++; $display("FAIL addi_imm_a got=%h exp=ffffffff", imm_a); end
    total++; if (imm_b !== 64'hFFFFFFFFFFFFFFFF) begin bad++; $display("FAIL addi_imm_b got=%h exp=ffffffffffffffff", imm_b); end
    step();
    in_instr = 32'h02131293;
    got = {v_a, k_a, il_a, rd_a, rs_a, sh_a}; exp = {1'b1, iak_srai, 1'b0, 5'd3, 5'd4, 6'd7};
    total++; if (got !== exp) begin bad++; $display("FAIL srai_a got=%h exp=%h", got, exp); end
    got = {v_b, k_b, il_b, rd_b, rs_b, sh_b};
    total++; if (got !== exp) begin bad++; $display("FAIL srai_b got=%h exp=%h", got, exp); end
    total++; if (imm_a !== 32'h00000407) begin bad++; $display("FAIL srai_imm_a got=%h exp=00000407", imm_a); end
    step();
    in_instr = 32'h0011011B;
    got = {v_a, k_a, il_a, rd_a, rs_a, sh_a}; exp = {1'b1, iak_invalid, 1'b1, 5'd5, 5'd6, 6'd0};
    total++; if (got !== exp) begin bad++; $display("FAIL slli33_a_illegal got=%h exp=%h", got, exp); end
    got = {v_b, k_b, il_b, rd_b, rs_b, sh_b}; exp = {1'b1, iak_slli, 1'b0, 5'd5, 5'd6, 6'd33};
    total++; if (got !== exp) begin bad++; $display("FAIL slli33_b got=%h exp=%h", got, exp); end
    total++; if (cnt_a !== 16'd0) begin bad++; $display("FAIL cnt_before_handoff got=%0d exp=0", cnt_a); end
    step();
    in_valid = 1'b0;
    got = {v_b, k_b, il_b, rd_b, rs_b, sh_b}; exp = {1'b1, iak_addiw, 1'b0, 5'd2, 5'd2, 6'd0};
    total++; if (got !== exp) begin bad++; $display("FAIL addiw_b got=%h exp=%h", got, exp); end
    total++; if (imm_b !== 64'd1) begin bad++; $display("FAIL addiw_imm_b got=%h exp=1", imm_b); end
    got = {v_a, k_a, il_a, rd_a, rs_a, sh_a}; exp = {1'b1, iak_invalid, 1'b1, 5'd2, 5'd2, 6'd0};
    total++; if (got !== exp) begin bad++; $display("FAIL addiw_a_illegal got=%h exp=%h", got, exp); end
    total++; if (cnt_a !== 16'd1) begin bad++; $display("FAIL cnt_after_first got=%0d exp=1", cnt_a); end
    step();
    total++;
    if ({v_a, cnt_a, cnt_b} !== {1'b0, 16'd2, 16'd0}) begin
      bad++; $display("FAIL drain_counts got v=%b cnt_a=%0d cnt_b=%0d exp v=0 cnt_a=2 cnt_b=0", v_a, cnt_a, cnt_b);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'hFFF10093;
    step();
    in_instr = 32'h40725193;
    step();
    in_instr = 32'h00000013;
    exp = {1'b1, iak_addi, 1'b0, 5'd1, 5'd2, 6'd0};
    got = {v_a, k_a, il_a, rd_a, rs_a, sh_a};
    total++; if (got !== exp) begin bad++; $display("FAIL bp_hold1 got=%h exp=%h", got, exp); end
    total++; if (rdy_a !== 1'b0) begin bad++; $display("FAIL bp_ready_low got=%b exp=0", rdy_a); end
    step();
    in_valid = 1'b0;
    got = {v_a, k_a, il_a, rd_a, rs_a, sh_a};
    total++; if (got !== exp || imm_a !== 32'hFFFFFFFF) begin bad++; $display("FAIL bp_hold2 got=%h imm=%h exp=%h imm=ffffffff", got, imm_a, exp); end
    out_ready = 1'b1;
    step();
    got = {v_a, k_a, il_a, rd_a, rs_a, sh_a}; exp = {1'b1, iak_srai, 1'b0, 5'd3, 5'd4, 6'd7};
    total++; if (got !== exp) begin bad++; $display("FAIL bp_skid_out got=%h exp=%h", got, exp); end
    total++; if (rdy_a !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b exp=1", rdy_a); end
    step();
    total++; if (v_a !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", v_a); end
  endtask

  task automatic test_flush();
    apply_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h00000000;
    step();
    in_instr = 32'h0011011B;
    step();
    total++; if ({v_a, rdy_a} !== 2'b10) begin bad++; $display("FAIL fl_full got v=%b rdy=%b exp v=1 rdy=0", v_a, rdy_a); end
    flush = 1'b1;
    in_instr = 32'hFFF10093;
    step();
    flush = 1'b0; in_valid = 1'b0;
    total++;
    if ({v_a, rdy_a, cnt_a} !== {1'b0, 1'b1, 16'd0}) begin
      bad++; $display("FAIL fl_cleared got v=%b rdy=%b cnt=%0d exp v=0 rdy=1 cnt=0", v_a, rdy_a, cnt_a);
    end
    out_ready = 1'b1;
    step();
    total++; if ({v_a, cnt_a} !== {1'b0, 16'd0}) begin bad++; $display("FAIL fl_dropped got v=%b cnt=%0d exp v=0 cnt=0", v_a, cnt_a); end
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00000000;
    step();
    in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0;
    total++; if ({v_a, cnt_a} !== {1'b0, 16'd1}) begin bad++; $display("FAIL fl_handoff_counts got v=%b cnt=%0d exp v=0 cnt=1", v_a, cnt_a); end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_c;
    apply_reset();
    out_ready = 1'b1; in_instr = 32'h00000000; in_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      if (i == 6) in_valid = 1'b0;
      step();
      if (i >= 2) begin
        exp_c = (i - 1 > 3) ? 2'd3 : 2'(i - 1);
        total++;
        if (cnt_c !== exp_c || cnt_a !== 16'(i - 1)) begin
          bad++; $display("FAIL sat_count%0d got c=%0d a=%0d exp c=%0d a=%0d", i - 1, cnt_c, cnt_a, exp_c, i - 1);
        end
      end
    end
    in_instr = 32'h40725193; in_valid = 1'b1;
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    got = {v_a, k_a, il_a, rd_a, rs_a, sh_a};
    total++; if (got !== '0 || imm_a !== '0) begin bad++; $display("FAIL midrst_fields got=%h imm=%h exp=0 imm=0", got, imm_a); end
    total++;
    if ({cnt_a, cnt_c, rdy_a, rdy_c, v_c} !== '0) begin
      bad++; $display("FAIL midrst_misc got cnt_a=%0d cnt_c=%0d rdy=%b%b v_c=%b exp all 0", cnt_a, cnt_c, rdy_a, rdy_c, v_c);
    end
    in_valid = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
